// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: fixed-priority sharing of the 4-digit display with minimum hold, linger and blanking
module seg_disp_arbiter #(
  parameter int HOLD_CYC = 2_400_000,
  parameter int IDLE_CYC = 24_000_000,
  parameter logic [3:0] BLANK = 4'hF
) (
  input  logic        clk_24m,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  ack,
  output logic [15:0] disp_digits,
  output logic [1:0]  disp_owner,
  output logic        disp_active
);
  localparam int MAXC = HOLD_CYC > IDLE_CYC ? HOLD_CYC : IDLE_CYC;
  localparam int CW = $clog2(MAXC);
  typedef enum logic [1:0] {IDLE, HOLD, LINGER} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] ack_n;
  logic [15:0] digits_n;
  logic [1:0] owner_n, w;
  logic active_n, hold_end, idle_end, grant;
  // next state and next registered outputs; a grant always beats the linger timeout
  always_comb begin
    hold_end = state == HOLD && cnt == CW'(HOLD_CYC - 1);
    idle_end = state == LINGER && cnt == CW'(IDLE_CYC - 1);
    grant = (state != HOLD || hold_end) && |req;
    w = req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
    state_n = state;
    cnt_n = state == IDLE ? '0 : cnt + 1'b1;
    ack_n = '0;
    digits_n = disp_digits;
    owner_n = disp_owner;
    active_n = disp_active;
    if (grant) begin
      state_n = HOLD;
      cnt_n = '0;
      ack_n = 3'b001 << w;
      digits_n = w == 2'd0 ? data0 : w == 2'd1 ? data1 : data2;
      owner_n = w;
      active_n = 1'b1;
    end else if (hold_end) begin
      state_n = LINGER;
      cnt_n = '0;
    end else if (idle_end) begin
      state_n = IDLE;
      cnt_n = '0;
      digits_n = {4{BLANK}};
      owner_n = 2'd3;
      active_n = 1'b0;
    end
  end
  // state, counter and all outputs registered; reset blanks the display at once
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ack <= '0;
      disp_digits <= {4{BLANK}};
      disp_owner <= 2'd3;
      disp_active <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ack <= ack_n;
      disp_digits <= digits_n;
      disp_owner <= owner_n;
      disp_active <= active_n;
    end
  end
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter: scoreboard bench with a grant-timestamp reference model
module tb_seg_disp_arbiter;
  localparam int HOLD = 8;
  localparam int IDLE = 16;
  typedef struct {
    int cyc;
    logic [2:0] ack;
    logic [15:0] dig;
    logic [1:0] own;
    logic act;
  } ev_t;
  logic clk_24m = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [15:0] data0 = '0, data1 = '0, data2 = '0;
  logic [2:0] ack;
  logic [15:0] disp_digits;
  logic [1:0] disp_owner;
  logic disp_active;
  ev_t sb[$];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int g = -1000;
  bit act_m = 0;
  logic [2:0] drop = '0;
  logic [15:0] p_dig = 16'hFFFF;
  logic [1:0] p_own = 2'd3;
  logic p_act = 1'b0;

  seg_disp_arbiter #(.HOLD_CYC(HOLD), .IDLE_CYC(IDLE), .BLANK(4'hF)) dut (
    .clk_24m(clk_24m), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1), .data2(data2),
    .ack(ack), .disp_digits(disp_digits), .disp_owner(disp_owner), .disp_active(disp_active)
  );

  always #5 clk_24m = ~clk_24m;
  always @(posedge clk_24m) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // one clock of stimulus: drop the source granted last edge, raise new ones, predict the next edge
  task automatic step(input logic [2:0] raise);
    int k;
    logic [1:0] w;
    ev_t e;
    req = (req | raise) & ~drop;
    drop = '0;
    k = cyc + 1;
    if ((!act_m || k - g >= HOLD) && req != 0) begin
      w = req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
      e.cyc = k;
      e.ack = 3'(1 << w);
      e.dig = w == 0 ? data0 : w == 1 ? data1 : data2;
      e.own = w;
      e.act = 1'b1;
      sb.push_back(e);
      g = k;
      act_m = 1;
      drop = e.ack;
    end else if (act_m && k == g + HOLD + IDLE) begin
      e.cyc = k;
      e.ack = '0;
      e.dig = 16'hFFFF;
      e.own = 2'd3;
      e.act = 1'b0;
      sb.push_back(e);
      act_m = 0;
    end
    @(posedge clk_24m);
    #1;
  endtask

  // monitor: every output event is matched against the queue; otherwise the display must not move
  always @(negedge clk_24m) begin
    ev_t e;
    if (!rst_n) begin
      p_dig = 16'hFFFF;
      p_own = 2'd3;
      p_act = 1'b0;
    end else begin
      if (ack !== 3'b000 || (p_act && !disp_active)) begin
        if (sb.size() == 0) chk("unexpected_event", {13'd0, ack, disp_digits}, 32'hDEAD);
        else begin
          e = sb.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("ack", {29'd0, ack}, {29'd0, e.ack});
          chk("digits", {16'd0, disp_digits}, {16'd0, e.dig});
          chk("owner_active", {29'd0, disp_owner, disp_active}, {29'd0, e.own, e.act});
        end
      end else if (disp_digits !== p_dig || disp_owner !== p_own || disp_active !== p_act)
        chk("stable", {13'd0, disp_active, disp_owner, disp_digits}, {13'd0, p_act, p_own, p_dig});
      p_dig = disp_digits;
      p_own = disp_owner;
      p_act = disp_active;
    end
  end

  initial begin
    repeat (3) @(posedge clk_24m);
    #1;
    chk("reset_state", {11'd0, ack, disp_active, disp_owner, disp_digits}, {11'd0, 3'b000, 1'b0, 2'd3, 16'hFFFF});
    rst_n = 1'b1;
    step('0);
    data1 = 16'h1234;
    step(3'b010);
    for (int i = 0; i < 12; i++) step('0);
    data0 = 16'h0001;
    data2 = 16'h0002;
    step(3'b101);
    data0 = 16'hAAAA;
    for (int i = 0; i < 11; i++) step('0);
    for (int i = 0; i < 3; i++) step('0);
    data0 = 16'h0C0C;
    step(3'b001);
    for (int i = 0; i < 40; i++) step('0);
    data2 = 16'h2222;
    step(3'b100);
    for (int i = 0; i < 40 && cyc + 1 != g + HOLD + IDLE; i++) step('0);
    data1 = 16'h5151;
    step(3'b010);
    for (int i = 0; i < 30; i++) step('0);
    data0 = 16'h7070;
    step(3'b001);
    for (int i = 0; i < 10 && cyc != g + 4; i++) step('0);
    data0 = 16'h0BAD;
    req = 3'b001;
    drop = '0;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {11'd0, ack, disp_active, disp_owner, disp_digits}, {11'd0, 3'b000, 1'b0, 2'd3, 16'hFFFF});
    act_m = 0;
    repeat (2) @(posedge clk_24m);
    #1;
    rst_n = 1'b1;
    step('0);
    for (int i = 0; i < 10; i++) step('0);
    for (int i = 0; i < 800; i++) begin
      logic [2:0] r;
      r = '0;
      for (int s = 0; s < 3; s++)
        if (!req[s] && $urandom_range(0, 14) == 0) begin
          r[s] = 1'b1;
          case (s)
            0: data0 = 16'($urandom);
            1: data1 = 16'($urandom);
            default: data2 = 16'($urandom);
          endcase
        end
      if ($urandom_range(0, 9) == 0) data1 = 16'($urandom);
      step(r);
    end
    for (int i = 0; i < 40; i++) step('0);
    chk("queue_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
